// File: rtl/wb_stream_writer.sv
// wb_stream_writer
//   Collects words from a valid/ready stream into a FIFO and writes them to
//   memory over a Wishbone master port as incrementing bursts. A Wishbone
//   config slave holds the transfer parameters and reports status.
//
// Ports
//   wb_clk_i, wb_rst_ni    clock, asynchronous active-low reset
//   wbs_*                  config slave. Registers by wbs_adr_i[4:2]:
//                            0 CTRL/STATUS (W: bit0 start, bit1 clear irq/err;
//                              R: {err, irq, busy})
//                            1 start_adr, 2 buf_size (bytes),
//                            3 burst_size (words), 4 tx_cnt (bytes, RO)
//   wbm_*                  memory master, write-only incrementing bursts
//   stream_s_*             stream sink feeding the FIFO
//   irq_o                  completion interrupt, level, held until cleared
//
// Build option
//   WB_STREAM_WRITER_ERR_EN  when defined, wbm_err_i during a burst aborts the
//                            transfer and sets err; otherwise wbm_err_i is
//                            ignored and STATUS bit2 reads 0.
//
// WB_AW is assumed not to exceed WB_DW (start_adr is written as a data word).
module wb_stream_writer #(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int FIFO_AW = 6
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic [4:0]           wbs_adr_i,
  input  logic [WB_DW-1:0]     wbs_dat_i,
  input  logic [WB_DW/8-1:0]   wbs_sel_i,
  input  logic                 wbs_we_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic [2:0]           wbs_cti_i,
  input  logic [1:0]           wbs_bte_i,
  output logic [WB_DW-1:0]     wbs_dat_o,
  output logic                 wbs_ack_o,
  output logic                 wbs_err_o,
  output logic [WB_AW-1:0]     wbm_adr_o,
  output logic [WB_DW-1:0]     wbm_dat_o,
  output logic [WB_DW/8-1:0]   wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  input  logic [WB_DW-1:0]     wbm_dat_i,
  input  logic [WB_DW-1:0]     stream_s_data_i,
  input  logic                 stream_s_valid_i,
  output logic                 stream_s_ready_o,
  output logic                 irq_o
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LW    = FIFO_AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

  state_t           r_state;
  logic             r_ack, r_busy, r_irq, r_err;
  logic [WB_DW-1:0] r_start_adr, r_buf_size, r_burst_size, r_tx_cnt, r_xfer_len;
  logic [WB_AW-1:0] r_xfer_adr, r_m_adr;
  logic [LW-1:0]    r_xfer_burst, r_beats_left;
  logic             r_cyc, r_stb, r_we;
  logic [2:0]       r_cti;
  logic [WB_DW-1:0] r_mem [DEPTH];
  logic [LW-1:0]    r_wr_ptr, r_rd_ptr;

  logic             w_wr, w_ctrl_wr, w_start, w_full, w_push, w_pop, w_flush, w_err_hit;
  logic [2:0]       w_reg;
  logic [LW-1:0]    w_level, w_beats, w_burst_clamp;
  logic [WB_DW-1:0] w_remain_words;
  logic             w_unused;

  assign w_reg     = wbs_adr_i[4:2];
  // Only the first cycle of an access (before ack) counts as the write.
  assign w_wr      = wbs_cyc_i & wbs_stb_i & wbs_we_i & ~r_ack;
  assign w_ctrl_wr = w_wr & (w_reg == 3'd0);
  assign w_start   = w_ctrl_wr & wbs_dat_i[0] & ~r_busy;

  assign w_level          = r_wr_ptr - r_rd_ptr;
  assign w_full           = (w_level == LW'(DEPTH));
  assign stream_s_ready_o = r_busy & ~w_full;
  assign w_push           = stream_s_valid_i & stream_s_ready_o;

`ifdef WB_STREAM_WRITER_ERR_EN
  assign w_err_hit = (r_state == S_BURST) & wbm_err_i;
`else
  assign w_err_hit = 1'b0;
`endif

  assign w_pop   = (r_state == S_BURST) & wbm_ack_i & ~w_err_hit;
  assign w_flush = w_start | w_err_hit;

  // Burst length register: 0 means single beat, never more than the FIFO holds.
  always_comb begin
    w_burst_clamp = r_burst_size[LW-1:0];
    if (r_burst_size == '0)
      w_burst_clamp = LW'(1);
    else if (r_burst_size > WB_DW'(DEPTH))
      w_burst_clamp = LW'(DEPTH);
  end

  // Next burst is the latched burst length, shortened to what is left.
  assign w_remain_words = (r_xfer_len - r_tx_cnt) >> 2;
  assign w_beats = (w_remain_words < WB_DW'(r_xfer_burst)) ? w_remain_words[LW-1:0]
                                                            : r_xfer_burst;

  always_comb begin
    wbs_dat_o = '0;
    case (w_reg)
      3'd0:    wbs_dat_o = {{(WB_DW-3){1'b0}}, r_err, r_irq, r_busy};
      3'd1:    wbs_dat_o = r_start_adr;
      3'd2:    wbs_dat_o = r_buf_size;
      3'd3:    wbs_dat_o = r_burst_size;
      3'd4:    wbs_dat_o = r_tx_cnt;
      default: wbs_dat_o = '0;
    endcase
  end

  // FIFO storage: data only, the pointers carry all state.
  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= stream_s_data_i;
  end

  assign wbm_dat_o = r_mem[r_rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LW'(1);
    end
  end

  // Config registers and master FSM.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state      <= S_IDLE;
      r_ack        <= 1'b0;
      r_busy       <= 1'b0;
      r_irq        <= 1'b0;
      r_err        <= 1'b0;
      r_start_adr  <= '0;
      r_buf_size   <= '0;
      r_burst_size <= '0;
      r_tx_cnt     <= '0;
      r_xfer_adr   <= '0;
      r_xfer_len   <= '0;
      r_xfer_burst <= '0;
      r_beats_left <= '0;
      r_m_adr      <= '0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_cti        <= 3'b000;
    end else begin
      r_ack <= wbs_cyc_i & wbs_stb_i & ~r_ack;
      if (w_wr) begin
        case (w_reg)
          3'd1:    r_start_adr  <= wbs_dat_i;
          3'd2:    r_buf_size   <= wbs_dat_i;
          3'd3:    r_burst_size <= wbs_dat_i;
          default: ;
        endcase
      end
      // Clear comes before any set below, so DONE/err in the same cycle wins.
      if (w_ctrl_wr && wbs_dat_i[1]) begin
        r_irq <= 1'b0;
        r_err <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_busy       <= 1'b1;
            r_tx_cnt     <= '0;
            r_xfer_adr   <= WB_AW'(r_start_adr);
            r_xfer_len   <= {r_buf_size[WB_DW-1:2], 2'b00};
            r_xfer_burst <= w_burst_clamp;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_tx_cnt >= r_xfer_len) begin
            r_state <= S_DONE;
          end else if (w_level >= w_beats) begin
            r_cyc        <= 1'b1;
            r_stb        <= 1'b1;
            r_we         <= 1'b1;
            r_m_adr      <= r_xfer_adr + WB_AW'(r_tx_cnt);
            r_cti        <= (w_beats == LW'(1)) ? 3'b111 : 3'b010;
            r_beats_left <= w_beats;
            r_state      <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_err_hit) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_cti   <= 3'b000;
            r_err   <= 1'b1;
            r_irq   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_pop) begin
            r_tx_cnt     <= r_tx_cnt + WB_DW'(4);
            r_m_adr      <= r_m_adr + WB_AW'(4);
            r_beats_left <= r_beats_left - LW'(1);
            if (r_beats_left == LW'(1)) begin
              r_cyc   <= 1'b0;
              r_stb   <= 1'b0;
              r_we    <= 1'b0;
              r_cti   <= 3'b000;
              r_state <= S_WAIT;
            end else if (r_beats_left == LW'(2)) begin
              r_cti <= 3'b111;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_irq   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_err_o = 1'b0;
  assign wbm_adr_o = r_m_adr;
  assign wbm_sel_o = '1;
  assign wbm_we_o  = r_we;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_stb;
  assign wbm_cti_o = r_cti;
  assign wbm_bte_o = 2'b00;
  assign irq_o     = r_irq;

  assign w_unused = ^{wbs_sel_i, wbs_cti_i, wbs_bte_i, wbs_adr_i[1:0], wbm_dat_i, wbm_err_i};

endmodule

// File: tb/tb_wb_stream_writer.sv
module tb_wb_stream_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i, wbs_cyc_i, wbs_stb_i;
  logic [2:0]  wbs_cti_i;
  logic [1:0]  wbs_bte_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [31:0] s_data;
  logic        s_valid, s_ready, irq_o;

  int tests = 0;
  int fails = 0;

  // Memory-side responder state (written only by the responder process)
  logic        ack_q = 1'b0;
  logic        err_q = 1'b0;
  logic        cyc_after_err = 1'b0;
  int          n_log = 0;
  int          cyc_cnt = 0;
  int          err_fired = -1;
  logic [31:0] log_adr [256];
  logic [31:0] log_dat [256];
  logic [2:0]  log_cti [256];

  // Responder controls (written only by the stimulus process)
  logic        ack_en;
  int          err_at;

  always #5 clk = ~clk;

  assign wbm_ack_i = ack_q;
  assign wbm_err_i = err_q;

  wb_stream_writer #(.WB_AW(32), .WB_DW(32), .FIFO_AW(2)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_dat_i(wbm_dat_i),
    .stream_s_data_i(s_data), .stream_s_valid_i(s_valid),
    .stream_s_ready_o(s_ready), .irq_o(irq_o)
  );

  // Responder: decides ack/err mid-cycle, logs each acked beat.
  always @(negedge clk) begin
    if (err_q) cyc_after_err = wbm_cyc_o;
    ack_q = 1'b0;
    err_q = 1'b0;
    if (wbm_cyc_o) cyc_cnt++;
    if (wbm_cyc_o && wbm_stb_o) begin
      if (n_log == err_at && err_fired != err_at) begin
        err_q     = 1'b1;
        err_fired = err_at;
      end else if (ack_en) begin
        ack_q = 1'b1;
        log_adr[n_log] = wbm_adr_o;
        log_dat[n_log] = wbm_dat_o;
        log_cti[n_log] = wbm_cti_o;
        n_log++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [2:0] r, input logic [31:0] d);
    int g = 0;
    wbs_adr_i = {r, 2'b00}; wbs_dat_i = d; wbs_we_i = 1'b1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    do begin @(negedge clk); g++; end while (!wbs_ack_o && g < 10);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    if (g >= 10) chk("wb_write_timeout", 32'(wbs_ack_o), 32'd1);
  endtask

  task automatic wb_read(input logic [2:0] r, output logic [31:0] d);
    int g = 0;
    wbs_adr_i = {r, 2'b00}; wbs_we_i = 1'b0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    do begin @(negedge clk); g++; end while (!wbs_ack_o && g < 10);
    d = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    if (g >= 10) chk("wb_read_timeout", 32'(wbs_ack_o), 32'd1);
  endtask

  task automatic send(input int n, input logic [31:0] base);
    int g;
    logic timed_out = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_data = base + i; s_valid = 1'b1;
      g = 0;
      while (!s_ready && g < 400) begin @(negedge clk); g++; end
      if (g >= 400) timed_out = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("send_timeout", 32'(timed_out), 32'd0);
  endtask

  task automatic wait_irq(input string tag);
    int g = 0;
    while (!irq_o && g < 3000) begin @(negedge clk); g++; end
    chk(tag, 32'(irq_o), 32'd1);
  endtask

  // Expected cti per beat: 111 on the last beat of each burst, bursts of bsz
  // words with a shorter final one.
  task automatic check_beats(input string tag, input int b0, input int n, input int bsz,
                             input logic [31:0] adr0, input logic [31:0] dat0);
    chk({tag, "_count"}, n_log - b0, n);
    for (int i = 0; i < n; i++) begin
      int pos, len;
      pos = i % bsz;
      len = (n - (i - pos) < bsz) ? n - (i - pos) : bsz;
      chk($sformatf("%s_adr%0d", tag, i), log_adr[b0+i], adr0 + 4*i);
      chk($sformatf("%s_dat%0d", tag, i), log_dat[b0+i], dat0 + i);
      chk($sformatf("%s_cti%0d", tag, i), 32'(log_cti[b0+i]), (pos == len-1) ? 32'd7 : 32'd2);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int b, c0, g;
    rst_n = 1'b0; ack_en = 1'b1; err_at = -1;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = 4'hF; wbs_we_i = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_cti_i = 3'b000; wbs_bte_i = 2'b00;
    wbm_dat_i = '0; s_data = '0; s_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_ack",   32'(wbs_ack_o), 32'd0);
    chk("rst_cyc",   32'(wbm_cyc_o), 32'd0);
    chk("rst_stb",   32'(wbm_stb_o), 32'd0);
    chk("rst_we",    32'(wbm_we_o),  32'd0);
    chk("rst_cti",   32'(wbm_cti_o), 32'd0);
    chk("rst_bte",   32'(wbm_bte_o), 32'd0);
    chk("rst_ready", 32'(s_ready),   32'd0);
    chk("rst_irq",   32'(irq_o),     32'd0);
    wb_read(3'd0, rd); chk("rst_status", rd, 32'd0);
    @(negedge clk);
    chk("ack_one_cycle", 32'(wbs_ack_o), 32'd0);

    // Register access
    wb_write(3'd1, 32'h0000_1000); wb_read(3'd1, rd); chk("rd_start_adr", rd, 32'h0000_1000);
    wb_write(3'd3, 32'd4);         wb_read(3'd3, rd); chk("rd_burst", rd, 32'd4);
    wb_write(3'd5, 32'hDEAD_BEEF); wb_read(3'd5, rd); chk("rd_unmapped", rd, 32'd0);

    // 64 bytes in 4-word bursts
    wb_write(3'd2, 32'd64);
    b = n_log;
    wb_write(3'd0, 32'h3);
    send(16, 32'hA000_0000);
    wait_irq("t64_irq");
    check_beats("t64", b, 16, 4, 32'h0000_1000, 32'hA000_0000);
    wb_read(3'd4, rd); chk("t64_txcnt", rd, 32'd64);
    wb_read(3'd0, rd); chk("t64_status", rd, 32'b010);

    // Zero-length transfer
    wb_write(3'd2, 32'd0);
    c0 = cyc_cnt;
    wb_write(3'd0, 32'h3);
    chk("z_busy", 32'(irq_o), 32'd0);
    repeat (3) @(negedge clk);
    chk("z_irq", 32'(irq_o), 32'd1);
    chk("z_nocyc", cyc_cnt - c0, 32'd0);
    wb_read(3'd0, rd); chk("z_status", rd, 32'b010);
    wb_write(3'd0, 32'h2);
    chk("z_irq_clr", 32'(irq_o), 32'd0);
    wb_read(3'd0, rd); chk("z_status_clr", rd, 32'd0);

    // 24 bytes (low bits of 27 ignored): bursts of 4 then 2
    wb_write(3'd1, 32'h0000_2000);
    wb_write(3'd2, 32'd27);
    wb_write(3'd3, 32'd4);
    b = n_log;
    wb_write(3'd0, 32'h3);
    send(6, 32'hB000_0000);
    wait_irq("t24_irq");
    check_beats("t24", b, 6, 4, 32'h0000_2000, 32'hB000_0000);
    wb_read(3'd4, rd); chk("t24_txcnt", rd, 32'd24);

    // burst_size 0 acts as single-beat bursts
    wb_write(3'd1, 32'h0000_3000);
    wb_write(3'd2, 32'd8);
    wb_write(3'd3, 32'd0);
    b = n_log;
    wb_write(3'd0, 32'h3);
    send(2, 32'hC000_0000);
    wait_irq("b0_irq");
    check_beats("b0", b, 2, 1, 32'h0000_3000, 32'hC000_0000);

    // Reset in the middle of a stalled burst (irq still set from above)
    wb_write(3'd1, 32'h0000_6000);
    wb_write(3'd2, 32'd32);
    wb_write(3'd3, 32'd4);
    b = n_log;
    wb_write(3'd0, 32'h1);
    send(4, 32'hD000_0000);
    g = 0;
    while (n_log < b + 4 && g < 500) begin @(negedge clk); g++; end
    repeat (2) @(negedge clk);
    ack_en = 1'b0;
    send(4, 32'hD000_0004);
    repeat (3) @(negedge clk);
    wbs_adr_i = 5'h10;
    #1;
    chk("mr_pre_cyc", 32'(wbm_cyc_o), 32'd1);
    chk("mr_pre_irq", 32'(irq_o), 32'd1);
    chk("mr_pre_txcnt", wbs_dat_o, 32'd16);
    rst_n = 1'b0;
    #1;
    chk("mr_cyc",   32'(wbm_cyc_o), 32'd0);
    chk("mr_irq",   32'(irq_o),     32'd0);
    chk("mr_txcnt", wbs_dat_o,      32'd0);
    chk("mr_ready", 32'(s_ready),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    b = n_log; c0 = cyc_cnt;
    repeat (10) @(negedge clk);
    chk("mr_no_beats", n_log - b, 32'd0);
    chk("mr_no_cyc", cyc_cnt - c0, 32'd0);

    // Small FIFO fills while acks are withheld; burst_size 9 clamps to 4
    ack_en = 1'b0;
    wb_write(3'd1, 32'h0000_4000);
    wb_write(3'd2, 32'd32);
    wb_write(3'd3, 32'd9);
    b = n_log;
    wb_write(3'd0, 32'h3);
    send(4, 32'h0000_0100);
    s_data = 32'h0000_0104; s_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("ff_ready_low", 32'(s_ready), 32'd0);
    chk("ff_cyc_stall", 32'(wbm_cyc_o), 32'd1);
    chk("ff_no_beats", n_log - b, 32'd0);
    ack_en = 1'b1;
    send(4, 32'h0000_0104);
    wait_irq("ff_irq");
    check_beats("ff", b, 8, 4, 32'h0000_4000, 32'h0000_0100);
    wb_read(3'd4, rd); chk("ff_txcnt", rd, 32'd32);

    // Bus error on the second beat
    wb_write(3'd1, 32'h0000_5000);
    wb_write(3'd2, 32'd16);
    wb_write(3'd3, 32'd4);
    err_at = n_log + 1;
    wb_write(3'd0, 32'h3);
    send(4, 32'hE000_0000);
    wait_irq("err_irq");
    repeat (2) @(negedge clk);
    wb_read(3'd0, rd);
`ifdef WB_STREAM_WRITER_ERR_EN
    chk("err_cyc_next", 32'(cyc_after_err), 32'd0);
    chk("err_status", rd, 32'b110);
    wb_read(3'd4, rd); chk("err_txcnt", rd, 32'd4);
`else
    chk("err_cyc_next", 32'(cyc_after_err), 32'd1);
    chk("err_status", rd, 32'b010);
    wb_read(3'd4, rd); chk("err_txcnt", rd, 32'd16);
`endif
    wb_write(3'd0, 32'h2);
    wb_read(3'd0, rd); chk("err_status_clr", rd, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_stream_writer.md
WB_STREAM_WRITER -- requirements
Module: wb_stream_writer

Interface
REQ-001 SHALL have parameters: WB_AW, 32, bus address width; WB_DW, 32, bus data width; FIFO_AW, 6, log2 of FIFO depth in words.
REQ-002 SHALL have ports, clock and reset first:
- wb_clk_i  in  1  sole clock.
- wb_rst_ni  in  1  asynchronous active-low reset.
- wbs_adr_i[4:0], wbs_dat_i[WB_DW], wbs_sel_i[WB_DW/8], wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_cti_i[3], wbs_bte_i[2]  in  config slave.
- wbs_dat_o[WB_DW], wbs_ack_o, wbs_err_o  out  config slave.
- wbm_adr_o[WB_AW], wbm_dat_o[WB_DW], wbm_sel_o[WB_DW/8], wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o[3], wbm_bte_o[2]  out  memory master.
- wbm_ack_i, wbm_err_i, wbm_dat_i[WB_DW]  in  memory master; wbm_dat_i unused.
- stream_s_data_i[WB_DW], stream_s_valid_i  in  stream sink.
- stream_s_ready_o  out  stream sink.
- irq_o  out  1  completion interrupt, level.

Function
REQ-003 SHALL ack each config access with wbs_ack_o high exactly one cycle, registered, one cycle after wbs_cyc_i&wbs_stb_i; writes take effect in the ack cycle; wbs_err_o tied 0.
REQ-004 SHALL decode wbs_adr_i[4:2]: 0 CTRL/STATUS, read {err,irq,busy} in bits 2:0; 1 start_adr; 2 buf_size (bytes); 3 burst_size (words); 4 tx_cnt (bytes written, read-only); others read 0, writes ignored.
REQ-005 SHALL on CTRL write: bit0=1 starts transfer if idle, ignored if busy; bit1=1 clears irq and err; both bits set in one write: clear applies first, then start.
REQ-006 SHALL on start: flush FIFO, clear tx_cnt, latch start_adr/buf_size/burst_size for the transfer, set busy.
REQ-007 SHALL use FIFO of 2^FIFO_AW words; stream_s_ready_o = busy & !fifo_full; word accepted when valid&ready.
REQ-008 SHALL run master FSM IDLE -> WAIT -> BURST -> WAIT ... -> DONE -> IDLE.
REQ-009 WAIT: SHALL enter BURST when FIFO level >= beats, beats = min(burst_size, remaining words); burst_size 0 treated as 1, values above FIFO depth clamped to depth.
REQ-010 BURST: SHALL drive cyc/stb/we=1, sel all ones, bte=00, cti=010 on all beats except last (111), single-beat burst cti=111; address = start_adr + 4*words_written.
REQ-011 SHALL pop FIFO and increment tx_cnt by 4 on each wbm_ack_i; drop cyc/stb the cycle after last ack.
REQ-012 SHALL go to DONE when 4*words_written >= buf_size (buf_size[1:0] ignored); buf_size 0 reaches DONE straight from start with no bus cycle.
REQ-013 DONE: SHALL clear busy, set irq for one DONE cycle edge, irq held until cleared by CTRL bit1 or reset.
REQ-014 SHALL keep wbs_dat_o combinational on wbs_adr_i; config writes to regs 1-3 during busy update registers but not the running transfer.
REQ-015 SHALL, on flush, drop unwritten FIFO words.

Reset
REQ-016 SHALL on wb_rst_ni low asynchronously clear: all registers, tx_cnt, FIFO pointers, busy, irq, err; outputs wbs_ack_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, stream_s_ready_o, irq_o all 0; wbm_cti_o, wbm_bte_o 0; FSM IDLE.
REQ-017 SHALL abort a bus burst immediately on reset mid-transfer, no further beats after release until new start.

Configuration
REQ-018 SHALL, with WB_STREAM_WRITER_ERR_EN defined: on wbm_err_i during BURST, end cycle next clock, set err and irq, clear busy, flush FIFO, go IDLE; err reads STATUS bit2.
REQ-019 SHALL, without WB_STREAM_WRITER_ERR_EN: ignore wbm_err_i, STATUS bit2 reads 0.

Verification
REQ-020 start_adr=0x1000, buf_size=64, burst_size=4, 16 stream words -> four 4-beat bursts at 0x1000/0x1010/0x1020/0x1030, cti 010,010,010,111 each; tx_cnt=64; irq=1.
REQ-021 buf_size=24, burst_size=4 -> bursts of 4 then 2 beats, second at start_adr+16, last beat cti=111; tx_cnt=24.
REQ-022 buf_size=0, start -> no wbm_cyc_o, busy drops, irq=1 within 3 cycles; CTRL write 0x2 -> irq=0.
REQ-023 FIFO_AW=2, stream valid held high, wbm_ack_i withheld -> stream_s_ready_o low after 4 words accepted, no data lost after acks resume.
REQ-024 ERR_EN defined, wbm_err_i on beat 2 -> cyc low next cycle, STATUS=0b110; undefined -> transfer completes, STATUS=0b010.
REQ-025 wb_rst_ni pulsed low mid-burst -> wbm_cyc_o, irq_o, tx_cnt 0 same cycle as assertion.
